// File: rtl/scope_capture_buf.sv
// scope_capture_buf: triggered circular capture buffer for digitizer samples.
// Accepted (decimated) samples are written into a 2^AW-deep RAM while armed.
// A trigger freezes the record after a programmable post-trigger count, and
// the localbus reads it back oldest-first with fixed 2-cycle read latency.
//
// Ports:
//   lb_clk, reset           clock, synchronous active-high reset
//   adc_data, adc_valid     sample stream (already in lb_clk domain)
//   decim                   keep every (decim+1)-th valid sample
//   pretrig                 pre-trigger sample count, latched on arm
//   arm                     start/restart pulse
//   trig_ext, trig_force    hardware (rising edge) / software triggers
//   lb_addr, lb_rd          record offset and read strobe
//   lb_rdata, lb_rd_valid   read data and 1-cycle qualifier
//   busy, done, trig_ptr    capture status and RAM address of trigger sample
module scope_capture_buf #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 16
) (
  input  logic          lb_clk,
  input  logic          reset,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic [7:0]    decim,
  input  logic [AW-1:0] pretrig,
  input  logic          arm,
  input  logic          trig_ext,
  input  logic          trig_force,
  input  logic [AW-1:0] lb_addr,
  input  logic          lb_rd,
  output logic [DW-1:0] lb_rdata,
  output logic          lb_rd_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] trig_ptr
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [AW-1:0] wp, wp_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          pend, pend_d;
  logic          trig_ext_q;
  logic [7:0]    dec_cnt, dec_d;
  logic [AW-1:0] pretrig_q, pretrig_d;
  logic [AW-1:0] trig_ptr_d;
  logic          busy_d, done_d;

  logic          accept_c;
  logic          we_c;
  logic          trig_evt_c;
  logic [CW-1:0] post_len_c;
  logic [CW-1:0] cnt_inc_c;
  logic [AW-1:0] rd_addr_c;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;
  logic          rd_q;

  // Sample qualification, trigger event detection and pointer arithmetic
  assign accept_c   = adc_valid && (dec_cnt == 8'd0);
  assign we_c       = accept_c && !arm && !reset &&
                      (state == S_PRE || state == S_WAIT || state == S_POST);
  assign trig_evt_c = trig_force | (trig_ext & ~trig_ext_q);
  assign post_len_c = CW'(DEPTH) - CW'(pretrig_q);
  assign cnt_inc_c  = cnt + CW'(1);
  assign rd_addr_c  = trig_ptr - pretrig_q + lb_addr;

  // Next-state and datapath update; arm overrides everything, dropping any trigger
  always_comb begin
    state_d    = state;
    wp_d       = wp;
    cnt_d      = cnt;
    pend_d     = pend;
    trig_ptr_d = trig_ptr;
    pretrig_d  = pretrig_q;
    dec_d      = dec_cnt;

    if (adc_valid) dec_d = (dec_cnt >= decim) ? 8'd0 : dec_cnt + 8'd1;
    if (we_c)      wp_d  = wp + AW'(1);

    if (arm) begin
      dec_d     = 8'd0;
      pretrig_d = pretrig;
      wp_d      = '0;
      cnt_d     = '0;
      pend_d    = 1'b0;
      state_d   = (pretrig == '0) ? S_WAIT : S_PRE;
    end else begin
      case (state)
        // Triggers are ignored here so the pre-trigger window is always full
        S_PRE: begin
          if (we_c) begin
            if (cnt_inc_c == CW'(pretrig_q)) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_c;
            end
          end
        end
        // The trigger sample itself counts as the first post-trigger sample
        S_WAIT: begin
          if (we_c && (pend || trig_evt_c)) begin
            trig_ptr_d = wp;
            pend_d     = 1'b0;
            cnt_d      = CW'(1);
            state_d    = (post_len_c == CW'(1)) ? S_DONE : S_POST;
          end else if (trig_evt_c) begin
            pend_d = 1'b1;
          end
        end
        S_POST: begin
          if (we_c) begin
            cnt_d = cnt_inc_c;
            if (cnt_inc_c == post_len_c) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  // State and control registers
  always_ff @(posedge lb_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wp         <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      trig_ext_q <= 1'b0;
      dec_cnt    <= 8'd0;
      pretrig_q  <= '0;
      trig_ptr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      wp         <= wp_d;
      cnt        <= cnt_d;
      pend       <= pend_d;
      trig_ext_q <= trig_ext;
      dec_cnt    <= dec_d;
      pretrig_q  <= pretrig_d;
      trig_ptr   <= trig_ptr_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Capture RAM: read-first on a same-address write/read collision
  always_ff @(posedge lb_clk) begin
    if (we_c)  mem[wp] <= adc_data;
    if (lb_rd) ram_q   <= mem[rd_addr_c];
  end

  // Second read stage: output register and valid pulse
  always_ff @(posedge lb_clk) begin
    if (reset) begin
      rd_q        <= 1'b0;
      lb_rd_valid <= 1'b0;
      lb_rdata    <= '0;
    end else begin
      rd_q        <= lb_rd;
      lb_rd_valid <= rd_q;
      if (rd_q) lb_rdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_scope_capture_buf.sv
// Testbench for scope_capture_buf (AW=4): table of capture scenarios with
// ramp data, plus hand sequences for re-arm in POST and reset in WAIT.
// Readout expectations go through a queue scoreboard that also checks latency.
module tb_scope_capture_buf;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;

  logic          lb_clk = 1'b0;
  logic          reset;
  logic [DW-1:0] adc_data;
  logic          adc_valid;
  logic [7:0]    decim;
  logic [AW-1:0] pretrig;
  logic          arm;
  logic          trig_ext;
  logic          trig_force;
  logic [AW-1:0] lb_addr;
  logic          lb_rd;
  logic [DW-1:0] lb_rdata;
  logic          lb_rd_valid;
  logic          busy;
  logic          done;
  logic [AW-1:0] trig_ptr;

  scope_capture_buf #(.AW(AW), .DW(DW)) dut (
    .lb_clk      (lb_clk),
    .reset       (reset),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .decim       (decim),
    .pretrig     (pretrig),
    .arm         (arm),
    .trig_ext    (trig_ext),
    .trig_force  (trig_force),
    .lb_addr     (lb_addr),
    .lb_rd       (lb_rd),
    .lb_rdata    (lb_rdata),
    .lb_rd_valid (lb_rd_valid),
    .busy        (busy),
    .done        (done),
    .trig_ptr    (trig_ptr)
  );

  always #5 lb_clk = ~lb_clk;

  // One capture scenario; exp_t is the accepted-sample index of the trigger
  typedef struct {
    int decim;
    int pretrig;
    bit ext;
    int trig_rel;
    int pre_pulse;
    bit arm_force;
    int exp_t;
  } row_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  row_t rows [7];
  exp_t sb [$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, and service the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge lb_clk);
    #1;
    cyc++;
    if (lb_rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_spurious: got valid with data %0d, expected no valid (cycle %0d)",
                 lb_rdata, cyc);
      end else begin
        e = sb.pop_front();
        chk("rd_data", int'(lb_rdata), int'(e.data));
        chk("rd_latency", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL rd_missing: got no valid, expected data %0d (cycle %0d)", e.data, cyc);
    end
  endtask

  // Arm, stream a ramp (value = cycles since arm-1), trigger, then read back
  task automatic run_row(input row_t rw, input int abort_at);
    int d1, jl, exp_done, done_rel;
    d1       = rw.decim + 1;
    jl       = rw.exp_t + 15 - rw.pretrig;
    exp_done = jl * d1 + 1;
    done_rel = -1;
    decim      = 8'(rw.decim);
    pretrig    = AW'(rw.pretrig);
    arm        = 1'b1;
    trig_force = rw.arm_force;
    trig_ext   = 1'b0;
    adc_valid  = 1'b1;
    adc_data   = 16'hffff;
    tick();
    arm        = 1'b0;
    trig_force = 1'b0;
    chk("busy_after_arm", int'(busy), 1);
    chk("done_after_arm", int'(done), 0);
    for (int r = 0; r < 400; r++) begin
      if (r == rw.trig_rel) begin
        chk("busy_before_trig", int'(busy), 1);
        chk("done_before_trig", int'(done), 0);
      end
      if (done) begin
        done_rel = r;
        break;
      end
      if (r == abort_at) begin
        trig_force = 1'b0;
        trig_ext   = 1'b0;
        chk("busy_mid_capture", int'(busy), 1);
        return;
      end
      adc_data   = DW'(r);
      trig_force = (!rw.ext && r == rw.trig_rel) || (r == rw.pre_pulse);
      trig_ext   = rw.ext && (r >= rw.trig_rel);
      tick();
    end
    trig_force = 1'b0;
    trig_ext   = 1'b0;
    chk("done_cycle", done_rel, exp_done);
    chk("busy_at_done", int'(busy), 0);
    chk("trig_ptr", int'(trig_ptr), rw.exp_t % 16);
    for (int i = 0; i < 16; i++) begin
      lb_rd   = 1'b1;
      lb_addr = AW'(i);
      sb.push_back('{data: DW'((rw.exp_t - rw.pretrig + i) * d1), due: cyc + 2});
      tick();
    end
    lb_rd = 1'b0;
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    //        decim pre ext trig pulse armf  T
    rows[0] = '{0,  4,  1'b0, 10, -1, 1'b0, 10};  // basic: 6..21, trigger at offset 4
    rows[1] = '{0,  0,  1'b1,  3, -1, 1'b0,  3};  // all post-trigger, ext edge
    rows[2] = '{2,  4,  1'b0, 20, -1, 1'b0,  7};  // decim 3, pending trigger
    rows[3] = '{0,  5,  1'b0, 46, -1, 1'b0, 46};  // wp wrapped twice, ptr 14
    rows[4] = '{1, 15,  1'b1, 40, -1, 1'b0, 20};  // post count of 1
    rows[5] = '{0,  6,  1'b0, 61,  2, 1'b0, 61};  // trigger during PRE discarded
    rows[6] = '{0,  0,  1'b1, 25, -1, 1'b1, 25};  // arm+force together: force dropped

    reset      = 1'b1;
    adc_data   = '0;
    adc_valid  = 1'b0;
    decim      = 8'd0;
    pretrig    = '0;
    arm        = 1'b0;
    trig_ext   = 1'b0;
    trig_force = 1'b0;
    lb_addr    = '0;
    lb_rd      = 1'b0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_trig_ptr", int'(trig_ptr), 0);
    chk("rst_rd_valid", int'(lb_rd_valid), 0);
    chk("rst_rdata", int'(lb_rdata), 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) run_row(rows[k], -1);

    // Re-arm while in POST: new capture must restart at address 0
    run_row(rows[0], 15);
    run_row(rows[1], -1);

    // Reset while in WAIT: back to IDLE, triggers then have no effect
    run_row(rows[2], 12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_wait_busy", int'(busy), 0);
    chk("rst_wait_done", int'(done), 0);
    chk("rst_wait_trig_ptr", int'(trig_ptr), 0);
    for (int r = 0; r < 20; r++) begin
      adc_data   = DW'(r);
      trig_force = r[0];
      tick();
    end
    trig_force = 1'b0;
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    run_row(rows[3], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scope_capture_buf.md
# scope_capture_buf

Triggered circular capture buffer between the digitizer sample path and the localbus readout inside `application_top`. Accepted ADC samples are written continuously into a 2^AW-deep RAM once armed. A trigger freezes the buffer after a programmable post-trigger count. The localbus reads the record in chronological order, with the oldest pre-trigger sample at offset 0. Single clock domain (`lb_clk`); samples have already been crossed into `lb_clk` upstream.

## Interface
- `AW`, 13: buffer address width; depth 2^AW samples
- `DW`, 16: sample width
- `lb_clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `adc_data`  in  DW  sample
- `adc_valid`  in  1  sample strobe
- `decim`  in  8  keep every (decim+1)-th valid sample
- `pretrig`  in  AW  samples retained before trigger; sampled on `arm`
- `arm`  in  1  single-cycle start pulse (localbus write strobe)
- `trig_ext`  in  1  hardware trigger, rising edge
- `trig_force`  in  1  software trigger pulse
- `lb_addr`  in  AW  record offset
- `lb_rd`  in  1  read strobe
- `lb_rdata`  out  DW  read data
- `lb_rd_valid`  out  1  read data qualifier
- `busy`  out  1  state is not IDLE and not DONE
- `done`  out  1  record complete
- `trig_ptr`  out  AW  RAM address of the trigger sample

## Operation
- Sample acceptance:
  - Decimation counter counts `adc_valid` cycles from 0 to decim and then wraps.
  - A sample is accepted when `adc_valid` is high and the counter is 0.
  - Counter clears on `arm`.
- Write pointer `wp` increments modulo 2^AW on every accepted sample, but only in PRE, WAIT or POST; it wraps silently.
- `pretrig` is latched on `arm`. Post count = 2^AW − pretrig_latched. A value of 0 gives all post-trigger.
- States:
  - IDLE: no writes.
  - PRE: write. Leave for WAIT after pretrig_latched accepted samples; if pretrig_latched = 0, go straight to WAIT on `arm`.
  - WAIT: write. Stay until a trigger coincides with an accepted sample; that sample is written, `trig_ptr` ← its address, and the state goes to POST with 1 sample counted.
  - POST: write until the post count is reached, then go to DONE.
  - DONE: no writes. Hold until `arm`.
- Trigger:
  - `trig_ext` rising edge (registered compare) or `trig_force`, latched as pending.
  - Pending is consumed on the next accepted sample in WAIT.
  - A trigger arriving in PRE is discarded, so the pre-trigger window is always full.
  - Pending clears on `arm`.
- `arm` from any state: restart to PRE (or WAIT), wp ← 0, clear `done`.
- Readout: RAM address = (trig_ptr − pretrig_latched + lb_addr) mod 2^AW.
  - Reads are allowed in any state.
  - Data is defined only when `done`; otherwise the value is whatever is in the RAM.
- Arithmetic: all pointer math unsigned AW bits with natural wrap; counters are AW+1 bits so that a full-depth post count fits.

## Timing
- Reset values:
  - state IDLE; `busy`=0, `done`=0.
  - `trig_ptr`=0, `lb_rdata`=0, `lb_rd_valid`=0.
  - wp, counters and pending trigger cleared.
  - RAM contents not reset.
- `arm` at cycle n: `busy`=1 at n+1. A sample accepted at n+1 is written to address 0.
- Trigger latency: `trig_ext` rising between samples is applied at the next accepted sample in WAIT.
- `done` rises the cycle after the final POST sample is written; `busy` falls in the same cycle.
- Read latency is fixed at 2: `lb_rd` at cycle n gives `lb_rdata`/`lb_rd_valid` at n+2. `lb_rd_valid` is a 1-cycle pulse.
- Reads are fully pipelined: back-to-back `lb_rd` gives back-to-back data.
- Simultaneous `arm` and trigger: `arm` wins, and the trigger is dropped.
- Simultaneous write and read of the same RAM address: read returns old data (read-first).
- `reset` mid-capture: IDLE next cycle, no further writes.

## Test plan
- AW=4, decim=0, pretrig=4, ramp samples 0,1,2… every cycle, arm, then `trig_force` after sample 9 → `done`; reading offsets 0..15 returns 6..21 with the trigger sample 10 at offset 4; `trig_ptr`=10.
- pretrig=0, `trig_ext` edge, ramp → offset 0 holds the trigger sample; exactly 16 samples written after trigger.
- decim=2, `adc_valid` every cycle, pretrig=4 → stored values step by 3; `done` after 3×16 valid cycles minus trigger-position offset, checked exactly.
- Trigger pulse during PRE then none → stays WAIT (`busy`=1, `done`=0) indefinitely; a later `trig_force` completes normally.
- Ramp run long enough for wp to wrap twice before trigger; trigger at address 14 with pretrig=5 → offset 0 maps to address 9; offsets 7..15 map to addresses 0..8 through the wrap.
- `arm` during POST, and `reset` during WAIT → capture restarts from address 0 / returns to IDLE; `lb_rd` at cycles 0,1,2 → valid at 2,3,4 with matching data.
